uart_rx_fifo: RTL and testbench

//  Receive-side byte buffer directly downstream of the UART receiver. The receiver's

---
 rtl/uart_rx_fifo_pkg.sv | 18 +
 rtl/uart_rx_fifo_if.sv | 13 +
 rtl/uart_fifo_ram.sv | 32 +++
 rtl/uart_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART byte-path definitions: default depth, byte width, AXIS byte type.
// No logic; types and constants only.
// Used by both the receive buffer and the transmit path.
package uart_rx_fifo_pkg;

    localparam int DEPTH_DEF = 16;
    localparam int BYTE_W    = 8;
    localparam int CNT_W_DEF = 8;

    typedef logic [BYTE_W-1:0] axis_byte_t;

    // FWFT output stage: nothing presented / head byte presented
    typedef enum logic {
        EMPTY_OUT = 1'b0,
        VALID_OUT = 1'b1
    } out_state_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// AXI-Stream byte link (tvalid/tdata/tready) between UART blocks.
// Pure wiring; no latency.
// The master holds tdata while tvalid=1 and tready=0.
interface uart_rx_fifo_if;
    import uart_rx_fifo_pkg::*;

    logic       tvalid;
    axis_byte_t tdata;
    logic       tready;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/uart_fifo_ram.sv
// DEPTH x 8 simple dual-port storage, one write port, one read port.
// Read data appears one cycle after the address; read-during-write returns old data.
// No flow control; the caller owns pointer and occupancy bookkeeping.
module uart_fifo_ram
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  axis_byte_t        wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output axis_byte_t        rd_dat
);

    axis_byte_t mem [DEPTH];

    // Write port: store byte at wr_addr
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Read port: registered read every cycle
    always_ff @(posedge i_clk) begin
        rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind the UART receiver, FWFT AXIS output, level and overflow reporting.
// Latency: write into empty FIFO appears on m_axis one cycle later; pops present next byte with no bubble.
// Input cannot be stalled: bytes arriving while full are dropped and counted; output honours tready.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    uart_rx_fifo_if.slave     s_axis,
    uart_rx_fifo_if.master    m_axis,
    output logic [ADDR_W:0]   o_level,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic [CNT_W-1:0]  o_drop_count,
    input  logic              i_clr_overflow
);

    localparam int LVL_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d, rd_addr;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              empty_q, full_q, ovf_q;
    logic [CNT_W-1:0]  cnt_q;
    out_state_t        state_q, state_d;
    axis_byte_t        dat_q, ram_rd_dat, head_dat, fwd_dat_q;
    logic              fwd_hit_q;
    logic              wr_en, pop, drop;
    logic              dat_ld, dat_from_wr;

    // The receiver cannot be stalled; overflow is counted instead
    assign s_axis.tready = 1'b1;

    // Full is judged on the registered state, so a same-cycle pop never rescues a byte
    assign pop      = (state_q == VALID_OUT) && m_axis.tready;
    assign wr_en    = s_axis.tvalid && !full_q && !i_rst;
    assign drop     = s_axis.tvalid && full_q;
    assign level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    assign rd_ptr_d = rd_ptr_q + ADDR_W'(pop);

    // Prefetch the slot after the next head so a pop can load it without a bubble
    assign rd_addr  = rd_ptr_d + ADDR_W'(1);

    // If that slot was written in the same cycle it was read, the RAM returned old data
    assign head_dat = fwd_hit_q ? fwd_dat_q : ram_rd_dat;

    uart_fifo_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_dat  (s_axis.tdata),
        .rd_addr (rd_addr),
        .rd_dat  (ram_rd_dat)
    );

    // Capture write data that collides with the prefetch read
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fwd_hit_q <= 1'b0;
            fwd_dat_q <= '0;
        end else begin
            fwd_hit_q <= wr_en && (wr_ptr_q == rd_addr);
            fwd_dat_q <= s_axis.tdata;
        end
    end

    // Pointers, occupancy and full/empty flags, all derived from the level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            empty_q  <= (level_d == '0);
            full_q   <= (level_d == LVL_W'(DEPTH));
        end
    end

    // Output stage state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= EMPTY_OUT;
        end else begin
            state_q <= state_d;
        end
    end

    // Output stage next state and head-register load selection
    always_comb begin
        state_d     = state_q;
        dat_ld      = 1'b0;
        dat_from_wr = 1'b0;
        unique case (state_q)
            EMPTY_OUT: begin
                if (wr_en) begin
                    state_d     = VALID_OUT;
                    dat_ld      = 1'b1;
                    dat_from_wr = 1'b1;
                end
            end
            VALID_OUT: begin
                if (pop) begin
                    if (level_q == LVL_W'(1)) begin
                        // Last stored byte leaves; only a same-cycle write keeps us valid
                        if (wr_en) begin
                            dat_ld      = 1'b1;
                            dat_from_wr = 1'b1;
                        end else begin
                            state_d = EMPTY_OUT;
                        end
                    end else begin
                        dat_ld = 1'b1;
                    end
                end
            end
        endcase
    end

    // Registered head byte; held while the consumer stalls
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dat_q <= '0;
        end else if (dat_ld) begin
            dat_q <= dat_from_wr ? s_axis.tdata : head_dat;
        end
    end

    // Sticky overflow and saturating drop count; a drop beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (drop) begin
            ovf_q <= 1'b1;
            if (i_clr_overflow) begin
                cnt_q <= CNT_W'(1);
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else if (i_clr_overflow) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end
    end

    assign m_axis.tvalid = (state_q == VALID_OUT);
    assign m_axis.tdata  = dat_q;
    assign o_level       = level_q;
    assign o_empty       = empty_q;
    assign o_full        = full_q;
    assign o_overflow    = ovf_q;
    assign o_drop_count  = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo at DEPTH=4: queue-based reference model,
// per-cycle compare on the falling edge, plus directed literal expectations.
module tb_uart_rx_fifo;
    import uart_rx_fifo_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_clr_overflow;
    logic [ADDR_W:0]   o_level;
    logic              o_empty, o_full, o_overflow;
    logic [CNT_W-1:0]  o_drop_count;

    uart_rx_fifo_if s_if ();
    uart_rx_fifo_if m_if ();

    always #5 i_clk = ~i_clk;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .s_axis         (s_if.slave),
        .m_axis         (m_if.master),
        .o_level        (o_level),
        .o_empty        (o_empty),
        .o_full         (o_full),
        .o_overflow     (o_overflow),
        .o_drop_count   (o_drop_count),
        .i_clr_overflow (i_clr_overflow)
    );

    int errs   = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus overflow flag and drop counter
    axis_byte_t mq[$];
    int  m_ovf = 0;
    int  m_cnt = 0;
    bit  model_on = 1'b0;
    bit  m_pop, m_full, m_drop;

    always @(posedge i_clk) begin
        if (i_rst) begin
            mq.delete();
            m_ovf    = 0;
            m_cnt    = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            m_pop  = (mq.size() != 0) && m_if.tready;
            m_full = (mq.size() == DEPTH);
            m_drop = s_if.tvalid && m_full;
            if (m_pop) void'(mq.pop_front());
            if (s_if.tvalid && !m_full) mq.push_back(s_if.tdata);
            if (m_drop) begin
                m_ovf = 1;
                m_cnt = i_clr_overflow ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
            end else if (i_clr_overflow) begin
                m_ovf = 0;
                m_cnt = 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge
    bit         stall_prev = 1'b0;
    axis_byte_t stall_dat;

    always @(negedge i_clk) begin
        if (model_on) begin
            check("tvalid", m_if.tvalid, (mq.size() != 0));
            if (mq.size() != 0) check("tdata", m_if.tdata, mq[0]);
            check("level", o_level, mq.size());
            check("empty", o_empty, (mq.size() == 0));
            check("full", o_full, (mq.size() == DEPTH));
            check("overflow", o_overflow, m_ovf);
            check("drop_count", o_drop_count, m_cnt);
            if (stall_prev) begin
                check("hold_tvalid", m_if.tvalid, 1);
                check("hold_tdata", m_if.tdata, stall_dat);
            end
            stall_prev = (mq.size() != 0) && !m_if.tready && !i_rst;
            if (mq.size() != 0) stall_dat = mq[0];
        end
    end

    // One clock of stimulus: drive inputs, step past the edge, return strobes to idle
    task automatic cyc(input bit vld, input axis_byte_t dat, input bit rdy, input bit clr);
        s_if.tvalid    = vld;
        s_if.tdata     = dat;
        m_if.tready    = rdy;
        i_clr_overflow = clr;
        @(posedge i_clk);
        #1;
        s_if.tvalid    = 1'b0;
        i_clr_overflow = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "timeout");
    end

    initial begin
        i_rst          = 1'b1;
        s_if.tvalid    = 1'b0;
        s_if.tdata     = '0;
        m_if.tready    = 1'b0;
        i_clr_overflow = 1'b0;
        @(posedge i_clk); #1;
        s_if.tvalid = 1'b1;             // ignored: arrives during reset
        s_if.tdata  = 8'hEE;
        @(posedge i_clk); #1;
        i_rst       = 1'b0;
        s_if.tvalid = 1'b0;
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_level", o_level, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_cnt", o_drop_count, 0);

        // Single byte, latency 1, then popped
        cyc(1, 8'h41, 1, 0);
        check("t1_tvalid", m_if.tvalid, 1);
        check("t1_tdata", m_if.tdata, 8'h41);
        check("t1_level", o_level, 1);
        cyc(0, 8'h00, 1, 0);
        check("t1_level0", o_level, 0);
        check("t1_empty", o_empty, 1);

        // Fill, overflow, ordered drain
        for (int i = 1; i <= 4; i++) cyc(1, axis_byte_t'(i), 0, 0);
        check("t2_full", o_full, 1);
        check("t2_level", o_level, 4);
        cyc(1, 8'h05, 0, 0);
        check("t2_ovf", o_overflow, 1);
        check("t2_cnt", o_drop_count, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t2_drain", m_if.tdata, i);
            cyc(0, 8'h00, 1, 0);
        end
        check("t2_empty", o_empty, 1);

        // Write while full in the same cycle as a pop: still dropped
        for (int i = 0; i < 4; i++) cyc(1, axis_byte_t'(8'h10 + i), 0, 0);
        cyc(1, 8'h99, 1, 0);
        check("t3_level", o_level, 3);
        check("t3_cnt", o_drop_count, 2);
        check("t3_tdata", m_if.tdata, 8'h11);
        for (int i = 1; i < 4; i++) begin
            check("t3_drain", m_if.tdata, 8'h10 + i);
            cyc(0, 8'h00, 1, 0);
        end

        // Clear, then sparse writes across several pointer wraps
        cyc(0, 8'h00, 1, 1);
        check("t4_clr_ovf", o_overflow, 0);
        check("t4_clr_cnt", o_drop_count, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, axis_byte_t'(8'h20 + i), 1, 0);
            check("t4_tdata", m_if.tdata, 8'h20 + i);
            repeat (3) cyc(0, 8'h00, 1, 0);
        end
        check("t4_cnt", o_drop_count, 0);
        check("t4_empty", o_empty, 1);

        // Random traffic and tready; the per-cycle compare does the work
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 3) == 0, axis_byte_t'($urandom), $urandom % 2, ($urandom % 64) == 0);
        end
        repeat (DEPTH + 1) cyc(0, 8'h00, 1, 0);
        check("t5_empty", o_empty, 1);

        // Drop counter saturation
        cyc(0, 8'h00, 1, 1);
        for (int i = 0; i < 4; i++) cyc(1, axis_byte_t'(8'h60 + i), 0, 0);
        for (int i = 0; i < 258; i++) cyc(1, 8'h77, 0, 0);
        check("sat_cnt", o_drop_count, 255);
        check("sat_head", m_if.tdata, 8'h60);

        // Clear coincident with a drop: the drop wins
        cyc(1, 8'hAB, 0, 1);
        check("t6_ovf", o_overflow, 1);
        check("t6_cnt", o_drop_count, 1);
        cyc(0, 8'h00, 1, 0);
        check("t6_level3", o_level, 3);

        // Reset with three bytes held
        i_rst       = 1'b1;
        m_if.tready = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("t6_rst_level", o_level, 0);
        check("t6_rst_tvalid", m_if.tvalid, 0);
        check("t6_rst_cnt", o_drop_count, 0);
        cyc(1, 8'h5A, 0, 0);
        check("t6_post_tdata", m_if.tdata, 8'h5A);
        check("t6_post_level", o_level, 1);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
